mm_arbiter: RTL and testbench

Round-robin arbiter that shares one Montgomery multiplier core (MM_top-class block: start/done handshake plus 17-bit bridge-BRAM master port) between `N_REQ` clients, each owning a private bridge BRAM. Sits between the client blocks (e.g. exponentiation sequencers) and the multiplier. It grants one client at a time, routes the multiplier's BRAM port to that client's BRAM, issues the start pulse, and returns a per-client done pulse. A watchdog aborts a hung operation.

---
 rtl/mm_arb_pkg.sv | 24 ++
 rtl/mm_arbiter_if.sv | 47 ++++
 rtl/mm_rr_picker.sv | 29 ++
 rtl/mm_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mm_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_arb_pkg.sv
// Shared types and widths for the Montgomery-multiplier round-robin arbiter.
package mm_arb_pkg;

  localparam int unsigned BRAM_W = 17;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WDOG_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    ABORT,
    RELEASE
  } state_t;

  // Multiplier-side BRAM access, broadcast to the clients
  typedef struct packed {
    logic [BRAM_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              en;
  } mm_bram_req_t;

endpackage

// File: rtl/mm_arbiter_if.sv
// Bundle of client, BRAM and multiplier signals around the arbiter.
interface mm_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import mm_arb_pkg::*;

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        done_o;
  logic                    err_o;
  logic                    busy_o;
  logic [$clog2(N_REQ)-1:0] owner_o;

  logic [N_REQ*BRAM_W-1:0] cl_bram_dout_i;
  logic [BRAM_W-1:0]       cl_bram_din_o;
  logic [ADDR_W-1:0]       cl_bram_addr_o;
  logic [N_REQ-1:0]        cl_bram_we_o;
  logic [N_REQ-1:0]        cl_bram_en_o;

  logic                    mm_start_o;
  logic                    mm_done_i;
  logic                    mm_reset_o;
  logic [BRAM_W-1:0]       mm_bram_dout_o;
  logic [BRAM_W-1:0]       mm_bram_din_i;
  logic [ADDR_W-1:0]       mm_bram_addr_i;
  logic                    mm_bram_we_i;
  logic                    mm_bram_en_i;

  // Arbiter view
  modport slave (
    input  req_i, cl_bram_dout_i, mm_done_i,
           mm_bram_din_i, mm_bram_addr_i, mm_bram_we_i, mm_bram_en_i,
    output gnt_o, done_o, err_o, busy_o, owner_o,
           cl_bram_din_o, cl_bram_addr_o, cl_bram_we_o, cl_bram_en_o,
           mm_start_o, mm_reset_o, mm_bram_dout_o
  );

  // Clients plus multiplier view
  modport master (
    output req_i, cl_bram_dout_i, mm_done_i,
           mm_bram_din_i, mm_bram_addr_i, mm_bram_we_i, mm_bram_en_i,
    input  gnt_o, done_o, err_o, busy_o, owner_o,
           cl_bram_din_o, cl_bram_addr_o, cl_bram_we_o, cl_bram_en_o,
           mm_start_o, mm_reset_o, mm_bram_dout_o
  );

endinterface

// File: rtl/mm_rr_picker.sv
// Combinational round-robin picker: first set request after `last`, with wrap.
module mm_rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] w_cand;

  // Walk offsets 1..N_REQ so `last` itself is the lowest-priority candidate
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      w_cand = IDX_W'((32'(last) + off) % N_REQ);
      if (!valid && req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin sharing of one Montgomery multiplier between N_REQ clients,
// with per-client BRAM routing and a BUSY watchdog.
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic         clock_i,
  input logic         reset_n_i,
  mm_arbiter_if.slave arb_if
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_owner, w_owner_nx;
  logic [IDX_W-1:0]   r_last, w_last_nx;
  logic [WDOG_W-1:0]  r_wdog, w_wdog_nx;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nx;
  logic [N_REQ-1:0]   r_done, w_done_nx;
  logic               r_err, w_err_nx;
  logic               r_busy, w_busy_nx;
  logic               r_start, w_start_nx;
  logic               r_mm_reset, w_mm_reset_nx;
  logic               r_rst_done;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_wdog_expire;
  mm_bram_req_t       w_mm_req;
  logic [BRAM_W-1:0]  w_rd_data;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  mm_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (arb_if.req_i),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_wdog_expire = (TIMEOUT_CYCLES != 0) &&
                         (r_wdog + WDOG_W'(1) == WDOG_W'(TIMEOUT_CYCLES));

  // Next state and next registered outputs
  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_last_nx     = r_last;
    w_wdog_nx     = r_wdog;
    w_gnt_nx      = '0;
    w_done_nx     = '0;
    w_err_nx      = 1'b0;
    w_busy_nx     = 1'b0;
    w_start_nx    = 1'b0;
    w_mm_reset_nx = ~r_rst_done;
    case (r_state)
      IDLE: begin
        if (r_rst_done && w_pick_valid) begin
          w_state_nx = START;
          w_owner_nx = w_pick_idx;
          w_last_nx  = w_pick_idx;
          w_wdog_nx  = '0;
          w_gnt_nx   = onehot(w_pick_idx);
          w_start_nx = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end
      START: begin
        w_state_nx = BUSY;
        w_wdog_nx  = '0;
        w_gnt_nx   = r_gnt;
        w_busy_nx  = 1'b1;
      end
      BUSY: begin
        w_busy_nx = 1'b1;
        // A done arriving on the expiry cycle completes normally
        if (arb_if.mm_done_i) begin
          w_state_nx = RELEASE;
          w_done_nx  = onehot(r_owner);
        end else if (w_wdog_expire) begin
          w_state_nx    = ABORT;
          w_gnt_nx      = r_gnt;
          w_mm_reset_nx = 1'b1;
        end else begin
          w_gnt_nx  = r_gnt;
          w_wdog_nx = r_wdog + WDOG_W'(1);
        end
      end
      ABORT: begin
        w_state_nx = RELEASE;
        w_done_nx  = onehot(r_owner);
        w_err_nx   = 1'b1;
        w_busy_nx  = 1'b1;
      end
      RELEASE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // r_rst_done delays FSM activity and the multiplier reset release by a clock
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IDX_W'(N_REQ - 1);
      r_wdog     <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_mm_reset <= 1'b1;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_last     <= w_last_nx;
      r_wdog     <= w_wdog_nx;
      r_gnt      <= w_gnt_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
      r_busy     <= w_busy_nx;
      r_start    <= w_start_nx;
      r_mm_reset <= w_mm_reset_nx;
      r_rst_done <= 1'b1;
    end
  end

  assign w_mm_req = '{din:  arb_if.mm_bram_din_i,
                      addr: arb_if.mm_bram_addr_i,
                      we:   arb_if.mm_bram_we_i,
                      en:   arb_if.mm_bram_en_i};

  // Read-data return path, zero when nobody holds the grant
  always_comb begin
    w_rd_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_gnt[k]) w_rd_data = arb_if.cl_bram_dout_i[k*BRAM_W +: BRAM_W];
    end
  end

  assign arb_if.cl_bram_din_o  = w_mm_req.din;
  assign arb_if.cl_bram_addr_o = w_mm_req.addr;
  assign arb_if.cl_bram_we_o   = {N_REQ{w_mm_req.we}} & r_gnt;
  assign arb_if.cl_bram_en_o   = {N_REQ{w_mm_req.en}} & r_gnt;
  assign arb_if.mm_bram_dout_o = w_rd_data;

  assign arb_if.gnt_o      = r_gnt;
  assign arb_if.done_o     = r_done;
  assign arb_if.err_o      = r_err;
  assign arb_if.busy_o     = r_busy;
  assign arb_if.owner_o    = r_owner;
  assign arb_if.mm_start_o = r_start;
  assign arb_if.mm_reset_o = r_mm_reset;

endmodule

// File: tb/tb_mm_arbiter.sv
// Bench for mm_arbiter: directed scenarios plus random traffic against a
// timeline-based model of each multiplier operation.
module tb_mm_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned T = 50;

  logic clk;
  logic rst_n;
  int   total, bad, cyc;

  // Model: one record for the current/last operation, in absolute cycles
  bit op, op_abort, op_hang, op_exact;
  int op_start, op_rel, owner_m, owner_prev, last_m;

  mm_arbiter_if #(.N_REQ(N)) arb ();

  mm_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .arb_if    (arb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int k);
    return 1'(v >> k);
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    if (op && cyc >= op_start && (op_rel < 0 || cyc < op_rel)) return onehot(owner_m);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_regs();
    bit inop, rel_now;
    inop    = op && cyc >= op_start && (op_rel < 0 || cyc <= op_rel);
    rel_now = op && cyc == op_rel;
    chk("gnt_o",      64'(arb.gnt_o),      64'(exp_gnt()));
    chk("done_o",     64'(arb.done_o),     rel_now ? 64'(onehot(owner_m)) : 64'(0));
    chk("err_o",      64'(arb.err_o),      64'(rel_now && op_abort));
    chk("busy_o",     64'(arb.busy_o),     64'(inop));
    chk("mm_start_o", 64'(arb.mm_start_o), 64'(op && cyc == op_start));
    chk("mm_reset_o", 64'(arb.mm_reset_o), 64'(op && op_abort && cyc == op_rel - 1));
    chk("owner_o",    64'(arb.owner_o),    (op && cyc >= op_start) ? 64'(owner_m) : 64'(owner_prev));
  endtask

  task automatic check_comb();
    logic [N-1:0] eg;
    logic [16:0]  ed;
    eg = exp_gnt();
    ed = (eg != '0) ? 17'(arb.cl_bram_dout_i >> (owner_m * 17)) : 17'd0;
    chk("mm_bram_dout_o", 64'(arb.mm_bram_dout_o), 64'(ed));
    chk("cl_bram_we_o",   64'(arb.cl_bram_we_o),   64'({N{arb.mm_bram_we_i}} & eg));
    chk("cl_bram_en_o",   64'(arb.cl_bram_en_o),   64'({N{arb.mm_bram_en_i}} & eg));
    chk("cl_bram_din_o",  64'(arb.cl_bram_din_o),  64'(arb.mm_bram_din_i));
    chk("cl_bram_addr_o", 64'(arb.cl_bram_addr_o), 64'(arb.mm_bram_addr_i));
  endtask

  // Consume this cycle's inputs: finish the running op or arbitrate a new one
  task automatic model_update();
    int pick;
    if (op && op_rel < 0 && cyc > op_start) begin
      if (arb.mm_done_i) begin
        op_rel = cyc + 1;
        op_abort = 1'b0;
      end else if (T != 0 && cyc - op_start == int'(T)) begin
        op_rel = cyc + 2;
        op_abort = 1'b1;
      end
    end else if ((!op || (op_rel >= 0 && cyc > op_rel)) && arb.req_i != '0) begin
      pick = -1;
      for (int i = 1; i <= int'(N); i++) begin
        int k;
        k = (last_m + i) % int'(N);
        if (pick < 0 && bit_of(arb.req_i, k)) pick = k;
      end
      if (op) owner_prev = owner_m;
      op       = 1'b1;
      op_start = cyc + 1;
      op_rel   = -1;
      op_abort = 1'b0;
      owner_m  = pick;
      last_m   = pick;
      op_hang  = ($urandom_range(5) == 0);
      op_exact = ($urandom_range(5) == 0);
    end
  endtask

  task automatic step();
    #1;
    check_comb();
    model_update();
    @(posedge clk);
    cyc++;
    #1;
    check_regs();
  endtask

  task automatic drive_random();
    logic [N-1:0] r, m;
    bit d;
    r = arb.req_i;
    for (int k = 0; k < int'(N); k++) begin
      m = onehot(k);
      if (op && owner_m == k && cyc == op_rel) begin
        if ($urandom_range(1) == 0) r = r & ~m;
      end else if (op && owner_m == k && op_rel < 0 && cyc > op_start) begin
        if ($urandom_range(31) == 0) r = r & ~m;
      end else if (!bit_of(r, k) && !(op && owner_m == k && op_rel < 0)) begin
        if ($urandom_range(3) == 0) r = r | m;
      end
    end
    d = 1'b0;
    if (op && op_rel < 0) begin
      if (cyc == op_start)  d = 1'($urandom_range(1));
      else if (op_exact)    d = (cyc - op_start == int'(T));
      else if (!op_hang)    d = ($urandom_range(7) == 0);
    end else begin
      d = ($urandom_range(15) == 0);
    end
    arb.req_i          = r;
    arb.mm_done_i      = d;
    arb.cl_bram_dout_i = 68'({$urandom, $urandom, $urandom});
    arb.mm_bram_din_i  = 17'($urandom);
    arb.mm_bram_addr_i = $urandom;
    arb.mm_bram_we_i   = 1'($urandom);
    arb.mm_bram_en_i   = 1'($urandom);
  endtask

  task automatic clear_inputs();
    arb.req_i          = '0;
    arb.mm_done_i      = 1'b0;
    arb.cl_bram_dout_i = '0;
    arb.mm_bram_din_i  = '0;
    arb.mm_bram_addr_i = '0;
    arb.mm_bram_we_i   = 1'b0;
    arb.mm_bram_en_i   = 1'b0;
  endtask

  // Entered just after an edge; asserts reset asynchronously mid-cycle
  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_gnt",   64'(arb.gnt_o),          64'(0));
    chk("rst_done",  64'(arb.done_o),         64'(0));
    chk("rst_err",   64'(arb.err_o),          64'(0));
    chk("rst_busy",  64'(arb.busy_o),         64'(0));
    chk("rst_start", 64'(arb.mm_start_o),     64'(0));
    chk("rst_owner", 64'(arb.owner_o),        64'(0));
    chk("rst_mmrst", 64'(arb.mm_reset_o),     64'(1));
    chk("rst_dout",  64'(arb.mm_bram_dout_o), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    op = 1'b0; op_rel = -1; owner_m = 0; owner_prev = 0; last_m = int'(N) - 1;
    @(posedge clk); cyc++; #1;
    chk("rel_mmrst_hold", 64'(arb.mm_reset_o), 64'(1));
    chk("rel_busy",       64'(arb.busy_o),     64'(0));
    @(posedge clk); cyc++; #1;
    chk("rel_mmrst_drop", 64'(arb.mm_reset_o), 64'(0));
  endtask

  int order[8];
  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int n, s, rc, dc, nrst;

  initial begin
    total = 0; bad = 0; cyc = 0;
    op = 1'b0; op_rel = -1; owner_m = 0; owner_prev = 0; last_m = int'(N) - 1;
    op_abort = 1'b0; op_hang = 1'b0; op_exact = 1'b0; op_start = 0;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two requesters after reset: client 1 wins, then client 3
    arb.req_i = 4'b1010;
    step();
    chk("p1_gnt",   64'(arb.gnt_o),      64'(4'b0010));
    chk("p1_start", 64'(arb.mm_start_o), 64'(1));
    step();
    chk("p1_start_once", 64'(arb.mm_start_o), 64'(0));
    step(); step();
    arb.mm_done_i = 1'b1;
    step();
    arb.mm_done_i = 1'b0;
    chk("p1_done", 64'(arb.done_o), 64'(4'b0010));
    arb.req_i = 4'b1000;
    step(); step();
    chk("p1_next_owner", 64'(arb.owner_o), 64'(3));
    chk("p1_next_gnt",   64'(arb.gnt_o),   64'(4'b1000));
    step();
    arb.mm_done_i = 1'b1;
    step();
    arb.mm_done_i = 1'b0;

    // All four clients requesting: strict rotation
    arb.req_i = 4'b1111;
    arb.mm_done_i = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      step();
      if (arb.mm_start_o) begin
        order[n] = int'(arb.owner_o);
        n++;
      end
    end
    arb.req_i = '0;
    chk("p2_ops_seen", 64'(n), 64'(8));
    for (int i = 0; i < 8; i++) chk("p2_order", 64'(order[i]), 64'(exp_ord[i]));
    for (int i = 0; i < 20 && arb.busy_o; i++) step();
    arb.mm_done_i = 1'b0;

    // Client 2 owns the port: read mux and write qualification
    arb.req_i = 4'b0100;
    step(); step();
    arb.cl_bram_dout_i = {17'h01111, 17'h15A5A, 17'h02222, 17'h03333};
    arb.mm_bram_addr_i = 32'd5;
    arb.mm_bram_din_i  = 17'h00123;
    arb.mm_bram_we_i   = 1'b1;
    arb.mm_bram_en_i   = 1'b1;
    #1;
    chk("p3_rdata", 64'(arb.mm_bram_dout_o), 64'(17'h15A5A));
    chk("p3_we",    64'(arb.cl_bram_we_o),   64'(4'b0100));
    chk("p3_en",    64'(arb.cl_bram_en_o),   64'(4'b0100));
    chk("p3_addr",  64'(arb.cl_bram_addr_o), 64'(5));
    step();
    arb.mm_done_i = 1'b1;
    step();
    arb.mm_done_i = 1'b0;
    arb.req_i = '0;
    chk("p3_done", 64'(arb.done_o), 64'(4'b0100));
    step();

    // Hung multiplier: watchdog abort
    arb.req_i = 4'b0001;
    step();
    s = cyc;
    chk("p4_start", 64'(arb.mm_start_o), 64'(1));
    nrst = 0; rc = -1; dc = -1;
    for (int i = 0; i < 80 && dc < 0; i++) begin
      step();
      if (arb.mm_reset_o) begin nrst++; rc = cyc; end
      if (arb.done_o != '0) dc = cyc;
    end
    chk("p4_reset_at",  64'(rc - s), 64'(T + 1));
    chk("p4_reset_cnt", 64'(nrst),   64'(1));
    chk("p4_done_at",   64'(dc - s), 64'(T + 2));
    chk("p4_done",      64'(arb.done_o), 64'(4'b0001));
    chk("p4_err",       64'(arb.err_o),  64'(1));
    arb.req_i = '0;
    step();

    // Done on the expiry cycle, owner drops its request mid-operation
    arb.req_i = 4'b0010;
    step();
    s = cyc;
    step();
    arb.req_i = '0;
    nrst = 0; dc = -1;
    for (int i = 0; i < 80 && dc < 0; i++) begin
      arb.mm_done_i = (cyc - s == int'(T));
      step();
      if (arb.mm_reset_o) nrst++;
      if (arb.done_o != '0) dc = cyc;
    end
    arb.mm_done_i = 1'b0;
    chk("p5_done_at", 64'(dc - s), 64'(T + 1));
    chk("p5_done",    64'(arb.done_o), 64'(4'b0010));
    chk("p5_err",     64'(arb.err_o),  64'(0));
    chk("p5_no_rst",  64'(nrst),       64'(0));
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    // Reset in the middle of BUSY
    arb.req_i = 4'b1111;
    arb.mm_done_i = 1'b0;
    for (int i = 0; i < 200 && !(op && op_rel < 0 && cyc > op_start + 1); i++) step();
    chk("p7_in_busy", 64'(op && op_rel < 0 && cyc > op_start + 1), 64'(1));
    do_reset();
    arb.req_i = 4'b1111;
    step();
    chk("p7_first_gnt", 64'(arb.gnt_o), 64'(4'b0001));
    arb.mm_done_i = 1'b1;
    step(); step();
    arb.req_i = '0;
    arb.mm_done_i = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
